// File: rtl/decode_stage.sv
// RV32I decode stage: instruction FIFO, head decode, and a registered EX control bundle.
// Define DECODE_ILLEGAL_TRAP_EN to flag undecodable encodings on o_Illegal_1.
module decode_stage #(
  parameter int PC_W       = 32,
  parameter int IBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_Valid_1,
  input  logic [PC_W-1:0]   i_PC,
  input  logic [31:0]       i_Inst,
  output logic              o_Ready_1,
  input  logic              i_Flush_1,
  output logic [4:0]        o_GRFReadAddr1_5,
  output logic [4:0]        o_GRFReadAddr2_5,
  input  logic [PC_W-1:0]   i_GRFReadData1_32,
  input  logic [PC_W-1:0]   i_GRFReadData2_32,
  output logic              o_Valid_1,
  input  logic              i_Ready_1,
  output logic [PC_W-1:0]   o_PC,
  output logic [4:0]        o_GRFWriteAddr_5,
  output logic              o_GRFWen_1,
  output logic [11:0]       o_ALUControl_12,
  output logic [PC_W-1:0]   o_ALUOperand1_32,
  output logic [PC_W-1:0]   o_ALUOperand2_32,
  output logic              o_Load_1,
  output logic              o_Store_1,
  output logic              o_LoadUnsigned_1,
  output logic [1:0]        o_LoadStoreWidth_2,
  output logic [PC_W-1:0]   o_StoreData_32,
  output logic [7:0]        o_JumpBranchType_8,
  output logic [PC_W-1:0]   o_CompareSrc1_32,
  output logic [PC_W-1:0]   o_CompareSrc2_32,
  output logic              o_UnsignedCMP_1,
  output logic              o_Illegal_1
);

  localparam int PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                         OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

  localparam logic [11:0] ALU_ADD = 12'h800, ALU_PC4 = 12'h400, ALU_SUB = 12'h200,
                          ALU_SLT = 12'h100, ALU_SLTU = 12'h080, ALU_AND = 12'h040,
                          ALU_OR = 12'h020, ALU_XOR = 12'h010, ALU_SLL = 12'h008,
                          ALU_SRL = 12'h004, ALU_SRA = 12'h002, ALU_LUI = 12'h001;

  logic [PC_W-1:0]  pc_mem   [IBUF_DEPTH];
  logic [31:0]      inst_mem [IBUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic             empty, push, pop, advance, hazard, issue;
  logic [PC_W-1:0]  head_pc;
  logic [31:0]      head_inst;
  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic [4:0]       rs1, rs2, rd;
  logic [PC_W-1:0]  imm_i, imm_s, imm_b, imm_j, imm_u, shamt;

  logic [11:0]      d_alu;
  logic [PC_W-1:0]  d_op1, d_op2;
  logic             d_wen, d_load, d_store, d_ucmp, d_use1, d_use2, d_known;
  logic [7:0]       d_jbt;

  assign empty     = (count == '0);
  assign o_Ready_1 = (count < CNT_W'(IBUF_DEPTH));
  assign push      = i_Valid_1 & o_Ready_1;
  assign advance   = ~o_Valid_1 | i_Ready_1;
  assign issue     = advance & ~empty & ~hazard;
  assign pop       = issue;

  // An empty buffer presents an all-zero word so the GRF read addresses fall to x0.
  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = empty ? 32'h0 : inst_mem[rd_ptr];

  assign opcode = head_inst[6:0];
  assign rd     = head_inst[11:7];
  assign funct3 = head_inst[14:12];
  assign rs1    = head_inst[19:15];
  assign rs2    = head_inst[24:20];
  assign funct7 = head_inst[31:25];

  assign o_GRFReadAddr1_5 = rs1;
  assign o_GRFReadAddr2_5 = rs2;

  assign imm_i = PC_W'($signed(head_inst[31:20]));
  assign imm_s = PC_W'($signed({head_inst[31:25], head_inst[11:7]}));
  assign imm_b = PC_W'($signed({head_inst[31], head_inst[7], head_inst[30:25], head_inst[11:8], 1'b0}));
  assign imm_j = PC_W'($signed({head_inst[31], head_inst[19:12], head_inst[20], head_inst[30:21], 1'b0}));
  assign imm_u = PC_W'($signed({head_inst[31:12], 12'h000}));
  assign shamt = PC_W'(head_inst[24:20]);

  always_comb begin
    d_alu   = '0;
    d_op1   = i_GRFReadData1_32;
    d_op2   = imm_i;
    d_wen   = 1'b0;
    d_load  = 1'b0;
    d_store = 1'b0;
    d_jbt   = '0;
    d_ucmp  = 1'b0;
    d_use1  = 1'b1;
    d_use2  = 1'b0;
    d_known = 1'b1;
    case (opcode)
      OP_LUI:   begin d_alu = ALU_LUI; d_op2 = imm_u; d_wen = 1'b1; d_use1 = 1'b0; end
      OP_AUIPC: begin d_alu = ALU_ADD; d_op1 = head_pc; d_op2 = imm_u; d_wen = 1'b1; d_use1 = 1'b0; end
      OP_JAL:   begin d_alu = ALU_PC4; d_op1 = head_pc; d_op2 = imm_j; d_wen = 1'b1; d_jbt = 8'h80; d_use1 = 1'b0; end
      OP_JALR:  begin
        if (funct3 == 3'b000) begin d_alu = ALU_PC4; d_wen = 1'b1; d_jbt = 8'h40; end
        else d_known = 1'b0;
      end
      OP_BRANCH: begin
        d_alu = ALU_ADD; d_op1 = head_pc; d_op2 = imm_b; d_use2 = 1'b1;
        case (funct3)
          3'b000:  d_jbt = 8'h20;
          3'b001:  d_jbt = 8'h10;
          3'b100:  d_jbt = 8'h08;
          3'b101:  d_jbt = 8'h02;
          3'b110:  begin d_jbt = 8'h04; d_ucmp = 1'b1; end
          3'b111:  begin d_jbt = 8'h01; d_ucmp = 1'b1; end
          default: d_known = 1'b0;
        endcase
      end
      OP_LOAD: begin
        if (funct3 != 3'b011 && funct3[2:1] != 2'b11) begin d_alu = ALU_ADD; d_load = 1'b1; d_wen = 1'b1; end
        else d_known = 1'b0;
      end
      OP_STORE: begin
        if (funct3[2] == 1'b0 && funct3 != 3'b011) begin d_alu = ALU_ADD; d_op2 = imm_s; d_store = 1'b1; d_use2 = 1'b1; end
        else d_known = 1'b0;
      end
      OP_IMM: begin
        d_wen = 1'b1;
        case (funct3)
          3'b000: d_alu = ALU_ADD;
          3'b010: d_alu = ALU_SLT;
          3'b011: d_alu = ALU_SLTU;
          3'b100: d_alu = ALU_XOR;
          3'b110: d_alu = ALU_OR;
          3'b111: d_alu = ALU_AND;
          3'b001: begin
            d_op2 = shamt;
            if (funct7 == 7'b0000000) d_alu = ALU_SLL; else d_known = 1'b0;
          end
          default: begin
            d_op2 = shamt;
            if (funct7 == 7'b0000000) d_alu = ALU_SRL;
            else if (funct7 == 7'b0100000) d_alu = ALU_SRA;
            else d_known = 1'b0;
          end
        endcase
      end
      OP_REG: begin
        d_op2 = i_GRFReadData2_32; d_use2 = 1'b1; d_wen = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  d_alu = ALU_ADD;
            3'b001:  d_alu = ALU_SLL;
            3'b010:  d_alu = ALU_SLT;
            3'b011:  d_alu = ALU_SLTU;
            3'b100:  d_alu = ALU_XOR;
            3'b101:  d_alu = ALU_SRL;
            3'b110:  d_alu = ALU_OR;
            default: d_alu = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) d_alu = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) d_alu = ALU_SRA;
        else d_known = 1'b0;
      end
      OP_FENCE, OP_SYSTEM: d_use1 = 1'b0;
      default: d_known = 1'b0;
    endcase
    // Anything undecodable leaves the stage as a harmless NOP.
    if (!d_known) begin
      d_alu = '0; d_wen = 1'b0; d_load = 1'b0; d_store = 1'b0;
      d_jbt = '0; d_ucmp = 1'b0; d_use1 = 1'b0; d_use2 = 1'b0;
    end
  end

  assign hazard = o_Valid_1 & o_Load_1 & (o_GRFWriteAddr_5 != 5'd0) &
                  ((d_use1 & (rs1 == o_GRFWriteAddr_5)) | (d_use2 & (rs2 == o_GRFWriteAddr_5)));

  always_ff @(posedge clk) begin
    if (push && !i_Flush_1) begin
      pc_mem[wr_ptr]   <= i_PC;
      inst_mem[wr_ptr] <= i_Inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_Flush_1) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // On a stalled advance only o_Valid_1 drops; the rest of the bundle is don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_Valid_1          <= 1'b0;
      o_PC               <= '0;
      o_GRFWriteAddr_5   <= '0;
      o_GRFWen_1         <= 1'b0;
      o_ALUControl_12    <= '0;
      o_ALUOperand1_32   <= '0;
      o_ALUOperand2_32   <= '0;
      o_Load_1           <= 1'b0;
      o_Store_1          <= 1'b0;
      o_LoadUnsigned_1   <= 1'b0;
      o_LoadStoreWidth_2 <= '0;
      o_StoreData_32     <= '0;
      o_JumpBranchType_8 <= '0;
      o_CompareSrc1_32   <= '0;
      o_CompareSrc2_32   <= '0;
      o_UnsignedCMP_1    <= 1'b0;
    end else if (i_Flush_1) begin
      o_Valid_1 <= 1'b0;
    end else if (advance) begin
      o_Valid_1 <= issue;
      if (issue) begin
        o_PC               <= head_pc;
        o_GRFWriteAddr_5   <= rd;
        o_GRFWen_1         <= d_wen & (rd != 5'd0);
        o_ALUControl_12    <= d_alu;
        o_ALUOperand1_32   <= d_op1;
        o_ALUOperand2_32   <= d_op2;
        o_Load_1           <= d_load;
        o_Store_1          <= d_store;
        o_LoadUnsigned_1   <= funct3[2];
        o_LoadStoreWidth_2 <= funct3[1:0];
        o_StoreData_32     <= i_GRFReadData2_32;
        o_JumpBranchType_8 <= d_jbt;
        o_CompareSrc1_32   <= i_GRFReadData1_32;
        o_CompareSrc2_32   <= i_GRFReadData2_32;
        o_UnsignedCMP_1    <= d_ucmp;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    o_Illegal_1 <= 1'b0;
    else if (!i_Flush_1 && advance && issue) o_Illegal_1 <= ~d_known;
  end
`else
  assign o_Illegal_1 = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with a small GRF model driving the read ports.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Valid_1, i_Flush_1, i_Ready_1;
  logic [31:0] i_PC, i_Inst;
  logic        o_Ready_1, o_Valid_1;
  logic [4:0]  o_GRFReadAddr1_5, o_GRFReadAddr2_5, o_GRFWriteAddr_5;
  logic [31:0] i_GRFReadData1_32, i_GRFReadData2_32;
  logic [31:0] o_PC, o_ALUOperand1_32, o_ALUOperand2_32, o_StoreData_32;
  logic [31:0] o_CompareSrc1_32, o_CompareSrc2_32;
  logic        o_GRFWen_1, o_Load_1, o_Store_1, o_LoadUnsigned_1, o_UnsignedCMP_1, o_Illegal_1;
  logic [11:0] o_ALUControl_12;
  logic [1:0]  o_LoadStoreWidth_2;
  logic [7:0]  o_JumpBranchType_8;

  logic [31:0] grf [32];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign i_GRFReadData1_32 = grf[o_GRFReadAddr1_5];
  assign i_GRFReadData2_32 = grf[o_GRFReadAddr2_5];

  decode_stage #(.PC_W(32), .IBUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .i_Valid_1(i_Valid_1), .i_PC(i_PC), .i_Inst(i_Inst), .o_Ready_1(o_Ready_1),
    .i_Flush_1(i_Flush_1),
    .o_GRFReadAddr1_5(o_GRFReadAddr1_5), .o_GRFReadAddr2_5(o_GRFReadAddr2_5),
    .i_GRFReadData1_32(i_GRFReadData1_32), .i_GRFReadData2_32(i_GRFReadData2_32),
    .o_Valid_1(o_Valid_1), .i_Ready_1(i_Ready_1),
    .o_PC(o_PC), .o_GRFWriteAddr_5(o_GRFWriteAddr_5), .o_GRFWen_1(o_GRFWen_1),
    .o_ALUControl_12(o_ALUControl_12),
    .o_ALUOperand1_32(o_ALUOperand1_32), .o_ALUOperand2_32(o_ALUOperand2_32),
    .o_Load_1(o_Load_1), .o_Store_1(o_Store_1), .o_LoadUnsigned_1(o_LoadUnsigned_1),
    .o_LoadStoreWidth_2(o_LoadStoreWidth_2), .o_StoreData_32(o_StoreData_32),
    .o_JumpBranchType_8(o_JumpBranchType_8),
    .o_CompareSrc1_32(o_CompareSrc1_32), .o_CompareSrc2_32(o_CompareSrc2_32),
    .o_UnsignedCMP_1(o_UnsignedCMP_1), .o_Illegal_1(o_Illegal_1)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    i_Valid_1 = 1'b1;
    i_PC      = pc;
    i_Inst    = inst;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_Valid_1 = 1'b0; i_Flush_1 = 1'b0; i_Ready_1 = 1'b1; i_PC = '0; i_Inst = '0;
    #12;
    n_vec++; if (o_Valid_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid got %h want 0", o_Valid_1); end
    n_vec++; if (o_Ready_1 !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready got %h want 1", o_Ready_1); end
    n_vec++; if (o_ALUControl_12 !== 12'h000) begin n_bad++; $display("[TB] FAIL reset_alu got %h want 000", o_ALUControl_12); end
    n_vec++; if (o_PC !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_pc got %h want 0", o_PC); end
    n_vec++; if (o_GRFWen_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wen got %h want 0", o_GRFWen_1); end
    n_vec++; if (o_GRFReadAddr1_5 !== 5'd0) begin n_bad++; $display("[TB] FAIL reset_raddr1 got %h want 0", o_GRFReadAddr1_5); end
    @(negedge clk);
    rst = 1'b0;
    step;
  endtask

  task automatic test_addi;
    offer(32'h100, 32'h00500093);
    step;
    i_Valid_1 = 1'b0;
    step;
    n_vec++; if (o_Valid_1 !== 1'b1) begin n_bad++; $display("[TB] FAIL addi_valid got %h want 1", o_Valid_1); end
    n_vec++; if (o_ALUControl_12 !== 12'h800) begin n_bad++; $display("[TB] FAIL addi_alu got %h want 800", o_ALUControl_12); end
    n_vec++; if (o_ALUOperand1_32 !== 32'h0) begin n_bad++; $display("[TB] FAIL addi_op1 got %h want 0", o_ALUOperand1_32); end
    n_vec++; if (o_ALUOperand2_32 !== 32'h5) begin n_bad++; $display("[TB] FAIL addi_op2 got %h want 5", o_ALUOperand2_32); end
    n_vec++; if (o_GRFWen_1 !== 1'b1) begin n_bad++; $display("[TB] FAIL addi_wen got %h want 1", o_GRFWen_1); end
    n_vec++; if (o_GRFWriteAddr_5 !== 5'd1) begin n_bad++; $display("[TB] FAIL addi_waddr got %h want 1", o_GRFWriteAddr_5); end
    n_vec++; if (o_PC !== 32'h100) begin n_bad++; $display("[TB] FAIL addi_pc got %h want 100", o_PC); end
    step;
    n_vec++; if (o_Valid_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL addi_drain got %h want 0", o_Valid_1); end
  endtask

  task automatic test_load_use;
    offer(32'h200, 32'h0000A103);
    step;
    offer(32'h204, 32'h001101B3);
    step;
    i_Valid_1 = 1'b0;
    n_vec++; if (o_Valid_1 !== 1'b1 || o_PC !== 32'h200) begin n_bad++; $display("[TB] FAIL lu_load_issue got v=%h pc=%h want v=1 pc=200", o_Valid_1, o_PC); end
    n_vec++; if (o_Load_1 !== 1'b1 || o_ALUOperand1_32 !== 32'h11) begin n_bad++; $display("[TB] FAIL lu_load_fields got ld=%h op1=%h want ld=1 op1=11", o_Load_1, o_ALUOperand1_32); end
    step;
    n_vec++; if (o_Valid_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL lu_bubble got %h want 0", o_Valid_1); end
    step;
    n_vec++; if (o_Valid_1 !== 1'b1 || o_PC !== 32'h204) begin n_bad++; $display("[TB] FAIL lu_add_issue got v=%h pc=%h want v=1 pc=204", o_Valid_1, o_PC); end
    n_vec++; if (o_ALUOperand1_32 !== 32'h22 || o_ALUOperand2_32 !== 32'h11) begin n_bad++; $display("[TB] FAIL lu_add_ops got %h/%h want 22/11", o_ALUOperand1_32, o_ALUOperand2_32); end
    n_vec++; if (o_GRFWriteAddr_5 !== 5'd3 || o_Load_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL lu_add_rd got rd=%h ld=%h want rd=3 ld=0", o_GRFWriteAddr_5, o_Load_1); end
    step;
    n_vec++; if (o_Valid_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL lu_drain got %h want 0", o_Valid_1); end
  endtask

  task automatic test_load_x0_no_bubble;
    offer(32'h300, 32'h0000A003);
    step;
    offer(32'h304, 32'h001101B3);
    step;
    i_Valid_1 = 1'b0;
    n_vec++; if (o_Load_1 !== 1'b1 || o_GRFWen_1 !== 1'b0 || o_PC !== 32'h300) begin n_bad++; $display("[TB] FAIL x0_load got ld=%h wen=%h pc=%h want 1/0/300", o_Load_1, o_GRFWen_1, o_PC); end
    step;
    n_vec++; if (o_Valid_1 !== 1'b1 || o_PC !== 32'h304) begin n_bad++; $display("[TB] FAIL x0_no_bubble got v=%h pc=%h want v=1 pc=304", o_Valid_1, o_PC); end
    step;
  endtask

  task automatic test_back_to_back;
    i_Ready_1 = 1'b0;
    offer(32'h400, 32'h00100093);
    step;
    offer(32'h404, 32'h00200113);
    step;
    n_vec++; if (o_Valid_1 !== 1'b1 || o_PC !== 32'h400) begin n_bad++; $display("[TB] FAIL stall_first got v=%h pc=%h want v=1 pc=400", o_Valid_1, o_PC); end
    offer(32'h408, 32'h00300193);
    step;
    n_vec++; if (o_Ready_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_full got %h want 0", o_Ready_1); end
    offer(32'h40C, 32'h00400213);
    for (int k = 0; k < 2; k++) begin
      step;
      n_vec++; if (o_Ready_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_ready%0d got %h want 0", k, o_Ready_1); end
      n_vec++; if (o_Valid_1 !== 1'b1 || o_PC !== 32'h400 || o_ALUOperand2_32 !== 32'h1) begin n_bad++; $display("[TB] FAIL stall_hold%0d got v=%h pc=%h op2=%h want 1/400/1", k, o_Valid_1, o_PC, o_ALUOperand2_32); end
    end
    i_Valid_1 = 1'b0;
    i_Ready_1 = 1'b1;
    step;
    n_vec++; if (o_Valid_1 !== 1'b1 || o_PC !== 32'h404 || o_ALUOperand2_32 !== 32'h2) begin n_bad++; $display("[TB] FAIL release_1 got v=%h pc=%h op2=%h want 1/404/2", o_Valid_1, o_PC, o_ALUOperand2_32); end
    step;
    n_vec++; if (o_Valid_1 !== 1'b1 || o_PC !== 32'h408 || o_ALUOperand2_32 !== 32'h3) begin n_bad++; $display("[TB] FAIL release_2 got v=%h pc=%h op2=%h want 1/408/3", o_Valid_1, o_PC, o_ALUOperand2_32); end
    step;
    n_vec++; if (o_Valid_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL release_end got %h want 0", o_Valid_1); end
  endtask

  task automatic test_flush;
    i_Ready_1 = 1'b0;
    offer(32'h500, 32'h00100093);
    step;
    offer(32'h504, 32'h00200113);
    step;
    offer(32'h508, 32'h00300193);
    step;
    n_vec++; if (o_Ready_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_prefull got %h want 0", o_Ready_1); end
    offer(32'h50C, 32'h00400213);
    i_Flush_1 = 1'b1;
    step;
    i_Flush_1 = 1'b0;
    i_Valid_1 = 1'b0;
    n_vec++; if (o_Valid_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_valid got %h want 0", o_Valid_1); end
    n_vec++; if (o_Ready_1 !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_ready got %h want 1", o_Ready_1); end
    i_Ready_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      n_vec++; if (o_Valid_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_leak%0d got v=%h pc=%h want v=0", k, o_Valid_1, o_PC); end
    end
  endtask

  task automatic test_srai;
    offer(32'h600, 32'h40335293);
    step;
    i_Valid_1 = 1'b0;
    step;
    n_vec++; if (o_ALUControl_12 !== 12'h002) begin n_bad++; $display("[TB] FAIL srai_alu got %h want 002", o_ALUControl_12); end
    n_vec++; if (o_ALUOperand2_32 !== 32'h3) begin n_bad++; $display("[TB] FAIL srai_op2 got %h want 3", o_ALUOperand2_32); end
    n_vec++; if (o_ALUOperand1_32 !== 32'hFFFFFF80 || o_GRFWriteAddr_5 !== 5'd5) begin n_bad++; $display("[TB] FAIL srai_op1_rd got %h/%h want ffffff80/5", o_ALUOperand1_32, o_GRFWriteAddr_5); end
    step;
  endtask

  task automatic test_branch;
    offer(32'h800, 32'h00208463);
    step;
    i_Valid_1 = 1'b0;
    step;
    n_vec++; if (o_JumpBranchType_8 !== 8'h20) begin n_bad++; $display("[TB] FAIL beq_type got %h want 20", o_JumpBranchType_8); end
    n_vec++; if (o_ALUOperand1_32 !== 32'h800 || o_ALUOperand2_32 !== 32'h8) begin n_bad++; $display("[TB] FAIL beq_ops got %h/%h want 800/8", o_ALUOperand1_32, o_ALUOperand2_32); end
    n_vec++; if (o_CompareSrc1_32 !== 32'h11 || o_CompareSrc2_32 !== 32'h22) begin n_bad++; $display("[TB] FAIL beq_cmp got %h/%h want 11/22", o_CompareSrc1_32, o_CompareSrc2_32); end
    n_vec++; if (o_GRFWen_1 !== 1'b0 || o_UnsignedCMP_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL beq_flags got wen=%h u=%h want 0/0", o_GRFWen_1, o_UnsignedCMP_1); end
    step;
  endtask

  task automatic test_illegal;
    logic exp_ill;
`ifdef DECODE_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    offer(32'h700, 32'hFFFFFFFF);
    step;
    i_Valid_1 = 1'b0;
    step;
    n_vec++; if (o_Valid_1 !== 1'b1 || o_PC !== 32'h700) begin n_bad++; $display("[TB] FAIL ill_issue got v=%h pc=%h want 1/700", o_Valid_1, o_PC); end
    n_vec++; if (o_Illegal_1 !== exp_ill) begin n_bad++; $display("[TB] FAIL ill_flag got %h want %h", o_Illegal_1, exp_ill); end
    n_vec++; if (o_GRFWen_1 !== 1'b0 || o_Load_1 !== 1'b0 || o_Store_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL ill_nop got wen=%h ld=%h st=%h want 0/0/0", o_GRFWen_1, o_Load_1, o_Store_1); end
    n_vec++; if (o_ALUControl_12 !== 12'h000 || o_JumpBranchType_8 !== 8'h00) begin n_bad++; $display("[TB] FAIL ill_ctrl got alu=%h jb=%h want 0/0", o_ALUControl_12, o_JumpBranchType_8); end
    step;
  endtask

  task automatic test_async_reset;
    i_Ready_1 = 1'b0;
    offer(32'h900, 32'h00100093);
    step;
    offer(32'h904, 32'h00200113);
    step;
    i_Valid_1 = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (o_Valid_1 !== 1'b0 || o_Ready_1 !== 1'b1) begin n_bad++; $display("[TB] FAIL areset_now got v=%h r=%h want 0/1", o_Valid_1, o_Ready_1); end
    @(negedge clk);
    rst = 1'b0;
    i_Ready_1 = 1'b1;
    step;
    step;
    n_vec++; if (o_Valid_1 !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_lost got %h want 0", o_Valid_1); end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) grf[r] = 32'h0;
    grf[1] = 32'h11;
    grf[2] = 32'h22;
    grf[6] = 32'hFFFFFF80;
    test_reset;
    test_addi;
    test_load_use;
    test_load_x0_no_bubble;
    test_back_to_back;
    test_flush;
    test_srai;
    test_branch;
    test_illegal;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
